// File: rtl/chip8_timers.sv
// chip8_timers: Chip-8 delay/sound timers driven by the 60 Hz tick, with a square-wave buzzer
// Ports: clk_in/reset (async, active-high) | tick_in 60 Hz tick (any width) |
//        dt_we/st_we/wdata timer loads | dt_out, dt_zero, sound_on, tone_out status and buzzer
module chip8_timers #(
    parameter logic [19:0] TONE_HALF = 20'd56818,
    parameter logic [7:0]  MIN_SOUND = 8'd2
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       dt_we,
    input  logic       st_we,
    input  logic [7:0] wdata,
    output logic [7:0] dt_out,
    output logic       dt_zero,
    output logic       sound_on,
    output logic       tone_out
);
    logic        tick_q;
    logic        tick_ev;
    logic [7:0]  st;
    logic [19:0] tc;

    // One event per tick, however long tick_in stays high
    assign tick_ev  = tick_in & ~tick_q;
    // Status flags decode registered state only
    assign dt_zero  = dt_out == 8'd0;
    assign sound_on = st != 8'd0;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            tick_q   <= 1'b0;
            dt_out   <= 8'd0;
            st       <= 8'd0;
            tc       <= 20'd0;
            tone_out <= 1'b0;
        end else begin
            tick_q <= tick_in;
            dt_out <= dt_we ? wdata : (tick_ev && dt_out != 8'd0) ? dt_out - 8'd1 : dt_out;
            st     <= st_we ? ((wdata < MIN_SOUND) ? 8'd0 : wdata)
                            : (tick_ev && st != 8'd0) ? st - 8'd1 : st;
            // Tone phase keeps running across ST reloads; only silence clears it
            if (!sound_on) begin
                tc       <= 20'd0;
                tone_out <= 1'b0;
            end else if (tc == TONE_HALF - 20'd1) begin
                tc       <= 20'd0;
                tone_out <= ~tone_out;
            end else begin
                tc <= tc + 20'd1;
            end
        end
    end
endmodule
